// File: rtl/mandlebrot_pkg.sv
// Shared types and defaults for the Mandelbrot frame scheduler.
// Holds the FSM state encoding and the pipeline slot bundle.
package mandlebrot_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 9;
  localparam int DEF_NUM_PIXELS = 512;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic                      valid;
    logic                      recirc;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] iter;
  } slot_t;

endpackage

// File: rtl/mandlebrot_slot_arbiter.sv
// Per-cycle slot decision: retire, recirculate or start a new pixel.
// Recirculation outranks new issue so in-flight pixels never starve.
module mandlebrot_slot_arbiter
  import mandlebrot_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  state_t                i_state,
  input  logic                  i_addr_left,
  input  logic [ADDR_WIDTH-1:0] i_next_addr,
  input  logic [DATA_WIDTH-1:0] i_cap,
  input  logic                  i_ret_valid,
  input  logic                  i_ret_escaped,
  input  logic [ADDR_WIDTH-1:0] i_ret_addr,
  input  logic [DATA_WIDTH-1:0] i_ret_iter,
  output logic                  o_retire,
  output logic                  o_new,
  output logic                  o_recirc,
  output logic                  o_valid,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_iter
);

  logic w_retire;
  logic w_recirc;
  logic w_new;

  assign w_retire = i_ret_valid &&
                    (i_ret_escaped || i_ret_iter >= i_cap);
  assign w_recirc = i_ret_valid && !w_retire;
  assign w_new    = !w_recirc && i_addr_left &&
                    (i_state == ST_RUN);

  assign o_retire = w_retire;
  assign o_recirc = w_recirc;
  assign o_new    = w_new;

  // Select what occupies the pipeline input slot next cycle.
  always_comb begin
    o_valid = 1'b0;
    o_addr  = '0;
    o_iter  = '0;
    unique case (1'b1)
      w_recirc: begin
        o_valid = 1'b1;
        o_addr  = i_ret_addr;
        o_iter  = i_ret_iter + 1'b1;
      end
      w_new: begin
        o_valid = 1'b1;
        o_addr  = i_next_addr;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mandlebrot_scheduler.sv
// Frame scheduler feeding the shared Mandelbrot iteration pipeline.
// Define MANDLEBROT_SCHED_STATS_EN for frame_cycles/recirc_count.
module mandlebrot_scheduler
  import mandlebrot_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_PIXELS = DEF_NUM_PIXELS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] max_iter,
  output logic                  busy,
  output logic                  done,
  output logic                  issue_valid,
  output logic                  issue_recirc,
  output logic [ADDR_WIDTH-1:0] issue_addr,
  output logic [DATA_WIDTH-1:0] issue_iter,
  input  logic                  ret_valid,
  input  logic [ADDR_WIDTH-1:0] ret_addr,
  input  logic [DATA_WIDTH-1:0] ret_iter,
  input  logic                  ret_escaped,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] d
`ifdef MANDLEBROT_SCHED_STATS_EN
  ,
  output logic [31:0]           frame_cycles,
  output logic [31:0]           recirc_count
`endif
);

  localparam logic [ADDR_WIDTH:0] LP_NPIX =
    (ADDR_WIDTH+1)'(NUM_PIXELS);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_cap;
  logic [ADDR_WIDTH:0]   r_next_addr;
  logic [ADDR_WIDTH:0]   r_inflight;

  logic                  w_accept;
  logic                  w_addr_left;
  logic                  w_retire;
  logic                  w_new;
  logic                  w_recirc;
  logic                  w_valid;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_iter;

  assign w_accept    = start &&
                       (r_state == ST_IDLE ||
                        r_state == ST_DONE);
  assign w_addr_left = r_next_addr < LP_NPIX;
  assign busy = (r_state == ST_RUN) ||
                (r_state == ST_DRAIN);
  assign done = (r_state == ST_DONE);

  mandlebrot_slot_arbiter #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_arb (
    .i_state       (r_state),
    .i_addr_left   (w_addr_left),
    .i_next_addr   (r_next_addr[ADDR_WIDTH-1:0]),
    .i_cap         (r_cap),
    .i_ret_valid   (ret_valid),
    .i_ret_escaped (ret_escaped),
    .i_ret_addr    (ret_addr),
    .i_ret_iter    (ret_iter),
    .o_retire      (w_retire),
    .o_new         (w_new),
    .o_recirc      (w_recirc),
    .o_valid       (w_valid),
    .o_addr        (w_addr),
    .o_iter        (w_iter)
  );

  // Frame FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Frame FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_accept) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (r_next_addr == LP_NPIX)
          w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (r_inflight == '0 && !ret_valid)
          w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Cap, pixel cursor and in-flight bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cap       <= '0;
      r_next_addr <= '0;
      r_inflight  <= '0;
    end else begin
      if (w_accept) begin
        r_cap       <= max_iter;
        r_next_addr <= '0;
      end else if (w_new) begin
        r_next_addr <= r_next_addr + 1'b1;
      end
      if (w_new && !w_retire)
        r_inflight <= r_inflight + 1'b1;
      else if (w_retire && !w_new)
        r_inflight <= r_inflight - 1'b1;
    end
  end

  // Registered pipeline slot and framebuffer write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_valid  <= 1'b0;
      issue_recirc <= 1'b0;
      issue_addr   <= '0;
      issue_iter   <= '0;
      we           <= 1'b0;
      waddr        <= '0;
      d            <= '0;
    end else begin
      issue_valid  <= w_valid;
      issue_recirc <= w_recirc;
      issue_addr   <= w_addr;
      issue_iter   <= w_iter;
      we           <= w_retire;
      waddr        <= w_retire ? ret_addr : '0;
      d            <= w_retire ? ret_iter : '0;
    end
  end

`ifdef MANDLEBROT_SCHED_STATS_EN
  // Per-frame cycle and recirculation counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cycles <= '0;
      recirc_count <= '0;
    end else if (w_accept) begin
      frame_cycles <= '0;
      recirc_count <= '0;
    end else if (busy) begin
      frame_cycles <= frame_cycles + 1'b1;
      if (w_recirc)
        recirc_count <= recirc_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mandlebrot_scheduler.sv
// Bench for mandlebrot_scheduler with a 23-deep pipeline model.
// Expected writes are queued at new issue and matched on we.
module tb_mandlebrot_scheduler;
  import mandlebrot_pkg::*;

  localparam int DEPTH  = 23;
  localparam int NPIX   = 512;
  localparam int BUDGET = 20000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] max_iter = '0;
  logic       busy, done;
  logic       issue_valid, issue_recirc;
  logic [8:0] issue_addr;
  logic [7:0] issue_iter;
  logic       ret_valid, ret_escaped;
  logic [8:0] ret_addr;
  logic [7:0] ret_iter;
  logic       we;
  logic [8:0] waddr;
  logic [7:0] d;

  int n_chk  = 0;
  int n_pass = 0;
  int mode   = 0;

  typedef struct {
    logic [8:0] a;
    logic [7:0] d;
  } exp_t;
  exp_t sb[$];

  slot_t pipe [DEPTH];

  always #5 clk = ~clk;

  mandlebrot_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .max_iter     (max_iter),
    .busy         (busy),
    .done         (done),
    .issue_valid  (issue_valid),
    .issue_recirc (issue_recirc),
    .issue_addr   (issue_addr),
    .issue_iter   (issue_iter),
    .ret_valid    (ret_valid),
    .ret_addr     (ret_addr),
    .ret_iter     (ret_iter),
    .ret_escaped  (ret_escaped),
    .we           (we),
    .waddr        (waddr),
    .d            (d)
  );

  assign ret_valid   = pipe[DEPTH-1].valid;
  assign ret_addr    = pipe[DEPTH-1].addr;
  assign ret_iter    = pipe[DEPTH-1].iter;
  assign ret_escaped = ret_valid &&
    (mode == 0 ||
     (mode == 2 && ret_addr == 9'd7 && ret_iter == 8'd2));

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {issue_valid, issue_recirc,
                  issue_addr, issue_iter};
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  function automatic logic [7:0] exp_d(
    input int m, input logic [8:0] a, input logic [7:0] c);
    if (m == 0) return 8'd0;
    if (m == 2 && a == 9'd7 && c > 8'd2) return 8'd2;
    return c;
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  task automatic chk_zero(input string p);
    check({p, "_ivalid"}, issue_valid, 0);
    check({p, "_irecirc"}, issue_recirc, 0);
    check({p, "_iaddr"}, issue_addr, 0);
    check({p, "_iiter"}, issue_iter, 0);
    check({p, "_we"}, we, 0);
    check({p, "_waddr"}, waddr, 0);
    check({p, "_d"}, d, 0);
    check({p, "_busy"}, busy, 0);
    check({p, "_done"}, done, 0);
  endtask

  task automatic run_frame(input logic [7:0] cap,
                           input int m,
                           input int stop_at,
                           input int poke_at,
                           input int exp_rc);
    int   n_new, n_wr, n_rc, cyc, k;
    bit   fin, poked, poke_chk;
    exp_t e;
    n_new = 0; n_wr = 0; n_rc = 0; cyc = 0;
    fin = 0; poked = 0; poke_chk = 0;
    mode = m;
    sb.delete();
    max_iter = cap;
    start = 1'b1;
    while (!fin && cyc < BUDGET) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      max_iter = cap;
      cyc++;
      if (poke_chk) begin
        check("poke_busy", busy, 1);
        check("poke_done", done, 0);
        poke_chk = 0;
      end
      if (issue_valid && !issue_recirc) begin
        check("new_addr", issue_addr, n_new);
        check("new_iter", issue_iter, 0);
        e.a = issue_addr;
        e.d = exp_d(m, issue_addr, cap);
        sb.push_back(e);
        n_new++;
      end
      if (issue_valid && issue_recirc) n_rc++;
      if (we) begin
        k = -1;
        for (int i = 0; i < sb.size(); i++)
          if (k < 0 && sb[i].a == waddr) k = i;
        check("wr_once", k >= 0, 1);
        if (k >= 0) begin
          check("wr_d", d, sb[k].d);
          sb.delete(k);
        end
        n_wr++;
      end
      if (poke_at >= 0 && !poked && n_new == poke_at) begin
        start = 1'b1;
        max_iter = 8'd9;
        poked = 1;
        poke_chk = 1;
      end
      if (stop_at >= 0 && n_new == stop_at) begin
        rst = 1'b1;
        #1;
        chk_zero("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        fin = 1;
      end else if (done) begin
        fin = 1;
      end
    end
    if (stop_at < 0) begin
      check("finished", fin, 1);
      check("n_new", n_new, NPIX);
      check("n_wr", n_wr, NPIX);
      check("sb_empty", sb.size(), 0);
      check("n_recirc", n_rc, exp_rc);
      check("end_busy", busy, 0);
      check("end_done", done, 1);
    end else begin
      check("stop_reached", fin, 1);
    end
  endtask

  initial begin
    #12;
    chk_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_busy", busy, 0);
    check("idle_valid", issue_valid, 0);

    run_frame(8'd5, 0, -1, -1, 0);
    run_frame(8'd5, 1, -1, 200, 2560);
    run_frame(8'd3, 2, -1, -1, 1535);
    run_frame(8'd5, 1, 100, -1, 0);
    run_frame(8'd5, 0, -1, -1, 0);
    run_frame(8'd0, 1, -1, -1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
